// File: rtl/lcd1602_frame_writer.sv
// lcd1602_frame_writer
//   Owns a 2x16 character frame buffer that the host writes at random. It
//   waits out panel power-up, sends the HD44780 init commands, and then
//   refreshes the panel from the buffer forever. Every bus transaction runs
//   four phases: SETUP, EN_HI, HOLD and GAP. Each phase length is a parameter.
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   wr_en/addr/data     frame buffer write (addr 0-15 row 0, 16-31 row 1)
//   init_done           high once 0x38,0x0C,0x06,0x01 have completed
//   frame_done          one-cycle pulse when row 1 column 15 has completed
//   lcd_rs/rw/en/dat    panel bus (rw tied low, write only)
//   lcd_bl_p/lcd_bl_n   backlight, constant on
module lcd1602_frame_writer #(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 16,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 2500,
  parameter int CLR_CYC   = 100000,
  parameter int PWRUP_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       frame_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       lcd_bl_p,
  output logic       lcd_bl_n
);
  localparam int MAXC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {PWRUP, INIT, ADDR0, ROW0, ADDR1, ROW1} seq_t;
  typedef enum logic [1:0] {SETUP, EN_HI, HOLD, GAP} ph_t;

  seq_t            seq, seq_n;
  ph_t             ph, ph_n;
  logic [3:0]      col, col_n;     // column index; in INIT it selects the command
  logic [CW-1:0]   cnt, cnt_n, len;
  logic            start, init_set, frame_set, rs_n;
  logic [7:0]      dat_n;
  logic [31:0][7:0] fbuf;

  assign lcd_rw   = 1'b0;
  assign lcd_bl_p = 1'b1;
  assign lcd_bl_n = 1'b0;

  always_comb begin
    // phase length; the clear command needs the long settle gap
    case (ph)
      SETUP:   len = CW'(SETUP_CYC);
      EN_HI:   len = CW'(EN_CYC);
      HOLD:    len = CW'(HOLD_CYC);
      default: len = (!lcd_rs && lcd_dat == 8'h01) ? CW'(CLR_CYC) : CW'(GAP_CYC);
    endcase
    if (seq == PWRUP) len = CW'(PWRUP_CYC);

    seq_n     = seq;
    ph_n      = ph;
    col_n     = col;
    cnt_n     = cnt + 1'b1;
    start     = 1'b0;
    init_set  = 1'b0;
    frame_set = 1'b0;
    if (cnt == len - 1'b1) begin
      cnt_n = '0;
      if (seq == PWRUP || ph == GAP) begin
        // end of the previous transaction: pick the next byte to send
        start = 1'b1;
        ph_n  = SETUP;
        case (seq)
          PWRUP: begin seq_n = INIT; col_n = '0; end
          INIT: begin
            col_n = col + 4'd1;
            if (col == 4'd3) begin seq_n = ADDR0; init_set = 1'b1; end
          end
          ADDR0: begin seq_n = ROW0; col_n = '0; end
          ROW0: begin
            col_n = col + 4'd1;
            if (col == 4'd15) seq_n = ADDR1;
          end
          ADDR1: begin seq_n = ROW1; col_n = '0; end
          default: begin
            col_n = col + 4'd1;
            if (col == 4'd15) begin seq_n = ADDR0; frame_set = 1'b1; end
          end
        endcase
      end else begin
        case (ph)
          SETUP:   ph_n = EN_HI;
          EN_HI:   ph_n = HOLD;
          default: ph_n = GAP;
        endcase
      end
    end

    rs_n = (seq_n == ROW0) || (seq_n == ROW1);
    case (seq_n)
      INIT: begin
        case (col_n[1:0])
          2'd0:    dat_n = 8'h38;
          2'd1:    dat_n = 8'h0C;
          2'd2:    dat_n = 8'h06;
          default: dat_n = 8'h01;
        endcase
      end
      ADDR0:   dat_n = 8'h80;
      ROW0:    dat_n = fbuf[{1'b0, col_n}];
      ADDR1:   dat_n = 8'hC0;
      ROW1:    dat_n = fbuf[{1'b1, col_n}];
      default: dat_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq        <= PWRUP;
      ph         <= SETUP;
      col        <= '0;
      cnt        <= '0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_dat    <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      seq        <= seq_n;
      ph         <= ph_n;
      col        <= col_n;
      cnt        <= cnt_n;
      lcd_en     <= (ph_n == EN_HI);
      frame_done <= frame_set;
      if (init_set) init_done <= 1'b1;
      // The character is sampled once at SETUP entry and then held. A write
      // to the same address on this edge lands after the read (old value sent).
      if (start) begin
        lcd_rs  <= rs_n;
        lcd_dat <= dat_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fbuf <= {32{8'h20}};
    else if (wr_en) fbuf[wr_addr] <= wr_data;
  end
endmodule
